gate_response_checker: RTL
==========================

Name: gate_response_checker

Overview:
Synthesizable self-checking reader for small combinational gate blocks such as and_gate and or_gate. It sweeps every input vector into the DUT, waits a settle interval, then samples the DUT output. Each sample is compared against an expected truth table, and the block reports pass/fail, the error count and the first failing vector. It sits beside a gate DUT in on-chip or FPGA self-test wrappers.

Parameters:
N_IN, 2, number of DUT inputs (1..4); sweeps 2**N_IN vectors
EXP_TT, 4'b1000, expected truth table, width 2**N_IN; bit i = expected output for input vector i
SETTLE, 5, cycles dut_in is held before sampling (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE or DONE
dut_in  out  N_IN  drive to DUT; dut_in[0]=A, dut_in[1]=B; vector index = dut_in
dut_out  in  1  DUT response (Y)
busy  out  1  high in SETTLE/SAMPLE
done  out  1  high in DONE, held until next start
pass  out  1  valid while done; 1 iff err_count==0
err_count  out  N_IN+1  mismatches this run
first_fail_vec  out  N_IN  vector of first mismatch; 0 if none
sample_valid  out  1  one-cycle pulse per compare
sample_vec  out  N_IN  vector just compared
sample_val  out  1  dut_out value just compared

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n. All registers update on the rising clk edge.
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, sample_valid=0, sample_vec=0, sample_val=0. State=IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1: vec=0, dut_in=0, err_count=0, first_fail_vec=0, done=0, pass=0, settle cnt=0. Go to SETTLE.
- SETTLE: cnt increments. When cnt==SETTLE-1, go to SAMPLE. dut_in is held stable.
- SAMPLE (exactly 1 cycle):
  - Compare dut_out with EXP_TT[vec].
  - Pulse sample_valid; load sample_vec=vec and sample_val=dut_out.
  - On mismatch: err_count+1. If this is the first mismatch, first_fail_vec=vec.
  - If vec==2**N_IN-1: go to DONE. Else: vec+1, dut_in=vec+1, cnt=0, go to SETTLE.
- DONE: done=1. pass=(err_count==0), using the final updated count. dut_in holds the last vector.
- Latency: each vector takes SETTLE+1 cycles. With start sampled at edge 0, done is first high after edge 2**N_IN*(SETTLE+1). Defaults: edge 24, so done is visible in cycle 25.
- start during busy is ignored; no restart and no queueing.
- err_count cannot overflow: width N_IN+1 holds up to 2**N_IN.
- Reset mid-sweep: rst_n low on any edge forces all reset values and IDLE. No partial results are kept.
- An X/Z on dut_out counts as a mismatch (simulation only; the compare uses !==).

Optional Feature:
Macro GATE_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE, with err_count=1 and pass=0. Remaining vectors are skipped.
- Undefined: all vectors are always swept.

Decomposition:
- Package gate_check_pkg holds:
  - typedef enum logic [1:0] chk_state_t {IDLE, SETTLE, SAMPLE, DONE}
  - constants TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111
- One natural sub-module: settle_timer (load/count/expire pulse, parameter SETTLE), instantiated once.

Test Plan:
1. DUT=and_gate, EXP_TT=TT_AND2, start pulse at edge 0.
   -> dut_in = 00, 01, 10, 11, 6 cycles each; sample_val = 0, 0, 0, 1.
   -> done first high after edge 24; pass=1, err_count=0.
2. DUT=or_gate, EXP_TT=TT_AND2.
   -> mismatches at vectors 01 and 10; err_count=2, first_fail_vec=01, pass=0.
3. rst_n=0 for one edge at edge 10 of a run.
   -> next cycle all outputs 0, busy=0; a fresh start then passes as in scenario 1.
4. start held high through a whole run.
   -> no restart while busy. After DONE, start re-launches at the next edge: err_count/first_fail_vec clear, done drops.
5. dut_out tied 1, EXP_TT=TT_AND2, GATE_CHECK_STOP_ON_FAIL_EN defined.
   -> fail at vector 00; done after edge 6; err_count=1, first_fail_vec=00.
6. dut_out = ~(A&B), EXP_TT=TT_AND2, macro undefined.
   -> err_count=4 (no wrap), first_fail_vec=00, pass=0.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the gate response checker.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } chk_state_t;

    // Truth tables for 2-input gates; bit i is the output for input vector i
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Settle interval timer: load clears the count, count advances while enabled,
// expire is asserted on the last cycle of the interval.
module settle_timer #(
    parameter int SETTLE = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [CW-1:0] cnt;

    // Count register; load has priority over counting
    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (en)   cnt <= cnt + CW'(1);
    end

    assign expire = en && (cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_response_checker.sv
// Self-checking sweeper for small combinational gates: drives every input
// vector, waits SETTLE cycles, samples the response and compares it with EXP_TT.
// Optional macro GATE_CHECK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]  EXP_TT = TT_AND2,
    parameter int                    SETTLE = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            sample_valid,
    output logic [N_IN-1:0] sample_vec,
    output logic            sample_val
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

    chk_state_t      state, state_n;
    logic [N_IN-1:0] vec, vec_n;
    logic [N_IN:0]   err_n;
    logic [N_IN-1:0] ff_n;
    logic            done_n, pass_n;
    logic            sv_n;
    logic [N_IN-1:0] svec_n;
    logic            sval_n;
    logic            timer_load, timer_expire;
    logic            mismatch, last;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (state == gate_check_pkg::SETTLE),
        .expire (timer_expire)
    );

    // X/Z on the response is treated as a failure
    assign mismatch = (dut_out !== EXP_TT[vec]);

    // Next-state and next-result logic
    always_comb begin
        state_n    = state;
        vec_n      = vec;
        err_n      = err_count;
        ff_n       = first_fail_vec;
        done_n     = done;
        pass_n     = pass;
        sv_n       = 1'b0;
        svec_n     = sample_vec;
        sval_n     = sample_val;
        timer_load = 1'b0;
        last       = 1'b0;
        case (state)
            gate_check_pkg::IDLE, gate_check_pkg::DONE: begin
                if (start) begin
                    vec_n      = '0;
                    err_n      = '0;
                    ff_n       = '0;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    timer_load = 1'b1;
                    state_n    = gate_check_pkg::SETTLE;
                end
            end
            gate_check_pkg::SETTLE: begin
                if (timer_expire) state_n = gate_check_pkg::SAMPLE;
            end
            gate_check_pkg::SAMPLE: begin
                sv_n   = 1'b1;
                svec_n = vec;
                sval_n = dut_out;
                if (mismatch) begin
                    err_n = err_count + (N_IN+1)'(1);
                    if (err_count == '0) ff_n = vec;
                end
                last = (vec == LAST_VEC);
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
                last = last || mismatch;
`endif
                if (last) begin
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                    state_n = gate_check_pkg::DONE;
                end else begin
                    vec_n      = vec + N_IN'(1);
                    timer_load = 1'b1;
                    state_n    = gate_check_pkg::SETTLE;
                end
            end
            default: state_n = gate_check_pkg::IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= gate_check_pkg::IDLE;
            vec            <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_vec     <= '0;
            sample_val     <= 1'b0;
        end else begin
            state          <= state_n;
            vec            <= vec_n;
            err_count      <= err_n;
            first_fail_vec <= ff_n;
            done           <= done_n;
            pass           <= pass_n;
            sample_valid   <= sv_n;
            sample_vec     <= svec_n;
            sample_val     <= sval_n;
        end
    end

    assign dut_in = vec;
    assign busy   = (state == gate_check_pkg::SETTLE) || (state == gate_check_pkg::SAMPLE);

endmodule
